// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared types and constants for the OV7670 SCCB writer
// Contents: FSM state enum, cmd_word field positions, bit/quarter counts,
// and a helper that flags the don't-care (ACK) bit slots.
package sccb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BITS  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    localparam int GO_BIT    = 31;
    localparam int DEV_LSB   = 16;
    localparam int REG_LSB   = 8;
    localparam int DAT_LSB   = 0;
    localparam int NBITS     = 27;
    localparam int NQUARTERS = 4;

    // Bit slots 8, 17 and 26 (0-based) are the 9th bit of each byte.
    function automatic logic is_ack_bit(input logic [4:0] b);
        return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
    endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// rtl/sccb_tick_gen.sv - quarter-bit-period tick divider
// Ports: clk, reset (sync, active-high), clear (restart count),
// en (count while high), qtick (one-cycle pulse every QUARTER enabled clocks).
module sccb_tick_gen #(
    parameter int QUARTER = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic qtick
);

    localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_end;

    assign at_end = (cnt_q == CW'(QUARTER - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_end ? '0 : cnt_q + CW'(1);
        end
    end

    assign qtick = en && at_end && !clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ov7670_sccb_writer.sv
// rtl/ov7670_sccb_writer.sv - one PIO command word to one SCCB 3-phase write
// Ports: clk, reset (sync, active-high), cmd_word {go[31], dev[23:16], reg[15:8], dat[7:0]},
// sccb_scl, sccb_sda_oe (1 = pull low), sccb_sda_in, busy, done, ack_err,
// status_word {29'b0, ack_err, done_seen, busy}.
// Optional: SCCB_ACK_CHECK_EN samples SDA at the ACK slots and sets a sticky ack_err.
module ov7670_sccb_writer
    import sccb_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int SCCB_FREQ_HZ = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cmd_word,
    output logic        sccb_scl,
    output logic        sccb_sda_oe,
    input  logic        sccb_sda_in,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic [31:0] status_word
);

    localparam int QUARTER = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);

    state_e      state_q, state_d;
    logic [1:0]  qcnt_q, qcnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] shift_q, shift_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        done_seen_q, done_seen_d;
    logic        ack_err_q, ack_err_d;
    logic        go_q, go_d;
    logic        scl_q, scl_d;
    logic        oe_q, oe_d;
    logic        qtick, trigger, last_quarter;

    // The done cycle is blocked so a new edge is only taken on the cycle after done.
    assign trigger      = (state_q == S_IDLE) && !done_q && cmd_word[GO_BIT] && !go_q;
    assign last_quarter = qtick && (qcnt_q == 2'(NQUARTERS - 1));

    sccb_tick_gen #(.QUARTER(QUARTER)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (trigger),
        .en    (busy_q),
        .qtick (qtick)
    );

`ifdef SCCB_ACK_CHECK_EN
    logic sda_s1_q, sda_s2_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            sda_s1_q <= 1'b0;
            sda_s2_q <= 1'b0;
        end else begin
            sda_s1_q <= sccb_sda_in;
            sda_s2_q <= sda_s1_q;
        end
    end
`else
    logic unused_sda_in;
    assign unused_sda_in = sccb_sda_in;
`endif

    always_comb begin
        state_d     = state_q;
        qcnt_d      = qcnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        done_seen_d = done_seen_q;
        ack_err_d   = ack_err_q;
        go_d        = cmd_word[GO_BIT];

        if (trigger) begin
            shift_d     = cmd_word[DEV_LSB+7:DAT_LSB];
            state_d     = S_START;
            qcnt_d      = 2'd0;
            bit_d       = 5'd0;
            busy_d      = 1'b1;
            done_seen_d = 1'b0;
            ack_err_d   = 1'b0;
        end else if (qtick) begin
            qcnt_d = qcnt_q + 2'd1;
            if (last_quarter) begin
                case (state_q)
                    S_START: begin
                        state_d = S_BITS;
                        bit_d   = 5'd0;
                    end
                    S_BITS: begin
                        // ACK slots carry no payload, so the shifter only advances on data bits.
                        if (!is_ack_bit(bit_q)) begin
                            shift_d = {shift_q[22:0], 1'b0};
                        end
                        if (bit_q == 5'(NBITS - 1)) begin
                            state_d = S_STOP;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                    S_STOP: begin
                        state_d     = S_IDLE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        done_seen_d = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

`ifdef SCCB_ACK_CHECK_EN
        // Sample at the end of q2, i.e. in the middle of the SCL high time.
        if ((state_q == S_BITS) && qtick && (qcnt_q == 2'd2) &&
            is_ack_bit(bit_q) && sda_s2_q) begin
            ack_err_d = 1'b1;
        end
`endif
    end

    // Pin levels are derived from the next state so they change together with it.
    always_comb begin
        scl_d = 1'b1;
        oe_d  = 1'b0;
        case (state_d)
            S_START: oe_d = qcnt_d[1];
            S_BITS: begin
                scl_d = qcnt_d[1];
                oe_d  = is_ack_bit(bit_d) ? 1'b0 : ~shift_d[23];
            end
            S_STOP: begin
                scl_d = (qcnt_d != 2'd0);
                oe_d  = !qcnt_d[1];
            end
            default: begin
                scl_d = 1'b1;
                oe_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            qcnt_q      <= 2'd0;
            bit_q       <= 5'd0;
            shift_q     <= 24'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_seen_q <= 1'b0;
            ack_err_q   <= 1'b0;
            go_q        <= 1'b0;
            scl_q       <= 1'b1;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_seen_q <= done_seen_d;
            ack_err_q   <= ack_err_d;
            go_q        <= go_d;
            scl_q       <= scl_d;
            oe_q        <= oe_d;
        end
    end

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^cmd_word[30:24];

    assign sccb_scl    = scl_q;
    assign sccb_sda_oe = oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign status_word = {29'd0, ack_err_q, done_seen_q, busy_q};

endmodule

// File: tb/tb_ov7670_sccb_writer.sv
// tb/tb_ov7670_sccb_writer.sv - scoreboard bench for ov7670_sccb_writer
module tb_ov7670_sccb_writer;

    localparam int CLK_HZ   = 4_000_000;
    localparam int SCCB_HZ  = 100_000;
    localparam int Q        = CLK_HZ / (4 * SCCB_HZ);
    localparam int TXN_CLKS = 116 * Q;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cmd_word;
    logic        sccb_scl, sccb_sda_oe, sda_in;
    logic        busy, done, ack_err;
    logic [31:0] status_word;

    typedef struct {
        logic [7:0] dev;
        logic [7:0] rg;
        logic [7:0] dat;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int nbits = 0;
    logic nack_req = 1'b0;

    ov7670_sccb_writer #(.CLK_FREQ_HZ(CLK_HZ), .SCCB_FREQ_HZ(SCCB_HZ)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_word    (cmd_word),
        .sccb_scl    (sccb_scl),
        .sccb_sda_oe (sccb_sda_oe),
        .sccb_sda_in (sda_in),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .status_word (status_word)
    );

    always #5 clk = ~clk;

    // Slave model: answers NACK across the second ACK slot when requested.
    assign sda_in = nack_req && (nbits == 17 || nbits == 18);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_ack_err(input logic nack);
`ifdef SCCB_ACK_CHECK_EN
        return nack;
`else
        return 1'b0 & nack;
`endif
    endfunction

    // Monitor: decodes the bus and checks each completed transaction against the scoreboard.
    initial begin : monitor
        logic [26:0] bits;
        logic        prev_scl, prev_sda, sda_now, start_seen, stop_seen;
        int          busy_cyc;
        exp_t        e;
        bits = '0; prev_scl = 1'b1; prev_sda = 1'b1;
        start_seen = 1'b0; stop_seen = 1'b0; busy_cyc = 0;
        forever begin
            @(negedge clk);
            sda_now = ~sccb_sda_oe;
            if (reset) begin
                nbits = 0; bits = '0; busy_cyc = 0;
                start_seen = 1'b0; stop_seen = 1'b0;
            end else begin
                if (prev_scl && sccb_scl && (sda_now != prev_sda)) begin
                    if (!sda_now && busy && nbits == 0) start_seen = 1'b1;
                    else if (sda_now && nbits == 27) stop_seen = 1'b1;
                    else begin
                        n_cmp++; n_fail++;
                        $display("FAIL bus_rule: SDA went %0d with SCL high after %0d bits, expected SDA stable", sda_now, nbits);
                    end
                end
                if (!prev_scl && sccb_scl && busy && nbits < 27) begin
                    bits = {bits[25:0], sda_now};
                    nbits++;
                end
                if (busy) busy_cyc++;
                if (done) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_done: done pulse %0d with empty scoreboard", done_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        check("start_cond", 32'(start_seen), 32'd1);
                        check("stop_cond", 32'(stop_seen), 32'd1);
                        check("bit_count", 32'(nbits), 32'd27);
                        check("dev_byte", 32'(bits[26:19]), 32'(e.dev));
                        check("reg_byte", 32'(bits[17:10]), 32'(e.rg));
                        check("dat_byte", 32'(bits[8:1]), 32'(e.dat));
                        check("ack_slots_released", 32'({bits[18], bits[9], bits[0]}), 32'h7);
                        check("busy_clocks", 32'(busy_cyc), 32'(TXN_CLKS));
                        check("busy_at_done", 32'(busy), 32'd0);
                        check("status_at_done", status_word, {29'd0, exp_ack_err(e.ack), 1'b1, 1'b0});
                    end
                    nbits = 0; bits = '0; busy_cyc = 0;
                    start_seen = 1'b0; stop_seen = 1'b0;
                end
            end
            prev_scl = sccb_scl;
            prev_sda = sda_now;
        end
    end

    task automatic start_txn(input logic [7:0] dev, input logic [7:0] rg, input logic [7:0] dat, input logic nack);
        exp_t e;
        cmd_word = {1'b0, 7'd0, dev, rg, dat};
        @(posedge clk); #1;
        e.dev = dev; e.rg = rg; e.dat = dat; e.ack = nack;
        exp_q.push_back(e);
        nack_req = nack;
        cmd_word[31] = 1'b1;
        @(posedge clk); #1;
        check("trigger_status", {30'd0, status_word[1:0]}, 32'h1);
    endtask

    task automatic wait_done();
        int  start;
        bit  seen;
        start = done_cnt;
        seen  = 0;
        for (int i = 0; i < 3 * TXN_CLKS; i++) begin
            @(posedge clk);
            if (done_cnt > start) begin
                seen = 1;
                break;
            end
        end
        #1;
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: no done within %0d clocks, expected one", 3 * TXN_CLKS);
        end
        nack_req = 1'b0;
    endtask

    initial begin : stim
        int   d0;
        logic any_busy;
        reset = 1'b1;
        cmd_word = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_scl", 32'(sccb_scl), 32'd1);
        check("reset_oe", 32'(sccb_sda_oe), 32'd0);
        check("reset_status", status_word, 32'h0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Fixed command 0x8042_1280.
        start_txn(8'h42, 8'h12, 8'h80, 1'b0);
        wait_done();
        cmd_word[31] = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Go toggled mid-transaction is ignored.
        d0 = done_cnt;
        start_txn(8'h42, 8'h3a, 8'h5c, 1'b0);
        repeat (300) @(posedge clk); #1;
        cmd_word[31] = 1'b0;
        repeat (5) @(posedge clk); #1;
        cmd_word[31] = 1'b1;
        wait_done();
        repeat (60) @(posedge clk); #1;
        check("single_done", 32'(done_cnt - d0), 32'd1);
        check("no_queued_txn", 32'(busy), 32'd0);

        // Go held high after done: no retrigger.
        any_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            any_busy |= busy;
        end
        check("no_retrigger", 32'(any_busy), 32'd0);
        cmd_word[31] = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset in quarter 50 of a transaction.
        start_txn(8'h42, 8'h77, 8'h01, 1'b0);
        repeat (49 * Q) @(posedge clk); #1;
        reset = 1'b1;
        cmd_word = 32'h0;
        nack_req = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("midreset_scl", 32'(sccb_scl), 32'd1);
        check("midreset_oe", 32'(sccb_sda_oe), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;
        start_txn(8'h42, 8'h40, 8'hc5, 1'b0);
        wait_done();
        cmd_word[31] = 1'b0;
        repeat (3) @(posedge clk); #1;

        // NACK on the second ACK slot.
        start_txn(8'h42, 8'h11, 8'h22, 1'b1);
        wait_done();
        cmd_word[31] = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Randomised commands.
        for (int n = 0; n < 4; n++) begin
            start_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            wait_done();
            cmd_word[31] = 1'b0;
            repeat ($urandom_range(2, 20)) @(posedge clk); #1;
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
